// File: rtl/pipelined_barrel_shifter.sv
// rtl/pipelined_barrel_shifter.sv - log2(WIDTH)-level barrel shifter (SRL/SLL/SRA/ROR) with valid/ready pipeline
// Optional out_sticky port enabled by SHIFTER_STICKY_EN.
module pipelined_barrel_shifter #(
    parameter int WIDTH     = 32,
    parameter int SH_W      = $clog2(WIDTH),
    parameter int PIPELINED = 0
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [WIDTH-1:0] in_data,
    input  logic [SH_W-1:0]  in_shamt,
    input  logic [1:0]       in_op,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] out_data,
    output logic             out_zero
`ifdef SHIFTER_STICKY_EN
    ,
    output logic             out_sticky
`endif
);

    typedef enum logic [1:0] {OP_SRL = 2'b00, OP_SLL = 2'b01, OP_SRA = 2'b10, OP_ROR = 2'b11} op_e;

    typedef struct packed {
        logic             valid;
        logic [WIDTH-1:0] data;
        logic [SH_W-1:0]  shamt;
        op_e              op;
        logic             sign;
`ifdef SHIFTER_STICKY_EN
        logic             sticky;
`endif
    } stage_t;

    localparam logic [WIDTH-1:0] ONES = '1;

    function automatic logic [WIDTH-1:0] rev(input logic [WIDTH-1:0] v);
        logic [WIDTH-1:0] r;
        for (int i = 0; i < WIDTH; i++) r[i] = v[WIDTH-1-i];
        return r;
    endfunction

    // One mux level: shift right by 2^k; SLL travels bit-reversed so it uses the SRL path.
    function automatic stage_t level(input stage_t s, input int k);
        stage_t           r;
        logic [WIDTH-1:0] sh;
        int               amt;
        r   = s;
        amt = 1 << k;
        if (s.shamt[k]) begin
            sh = s.data >> amt;
            if (s.op == OP_ROR) sh = sh | (s.data << (WIDTH - amt));
            else if (s.op == OP_SRA && s.sign) sh = sh | ~(ONES >> amt);
`ifdef SHIFTER_STICKY_EN
            if (s.op != OP_ROR && (s.data & ~(ONES << amt)) != '0) r.sticky = 1'b1;
`endif
            r.data = sh;
        end
        return r;
    endfunction

    stage_t           pipe_q [SH_W-1];
    stage_t           pipe_d [SH_W-1];
    logic             out_valid_q, out_valid_d;
    logic [WIDTH-1:0] out_data_q, out_data_d;
    logic             out_zero_q, out_zero_d;
`ifdef SHIFTER_STICKY_EN
    logic             out_sticky_q, out_sticky_d;
`endif
    logic             adv;
    stage_t           cur;

    assign adv      = !out_valid_q || out_ready;
    assign in_ready = adv;

    always_comb begin
        pipe_d      = pipe_q;
        out_valid_d = out_valid_q;
        out_data_d  = out_data_q;
        out_zero_d  = out_zero_q;
`ifdef SHIFTER_STICKY_EN
        out_sticky_d = out_sticky_q;
`endif
        cur.valid = in_valid;
        cur.data  = (op_e'(in_op) == OP_SLL) ? rev(in_data) : in_data;
        cur.shamt = in_shamt;
        cur.op    = op_e'(in_op);
        cur.sign  = in_data[WIDTH-1];
`ifdef SHIFTER_STICKY_EN
        cur.sticky = 1'b0;
`endif
        cur = level(cur, 0);
        for (int k = 1; k < SH_W; k++) begin
            if (adv) pipe_d[k-1] = cur;
            if (PIPELINED != 0) cur = pipe_q[k-1];
            cur = level(cur, k);
        end
        // Output stage keeps its last result across bubbles.
        if (adv) begin
            out_valid_d = cur.valid;
            if (cur.valid) begin
                out_data_d = (cur.op == OP_SLL) ? rev(cur.data) : cur.data;
                out_zero_d = (cur.data == '0);
`ifdef SHIFTER_STICKY_EN
                out_sticky_d = cur.sticky;
`endif
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int k = 0; k < SH_W - 1; k++) pipe_q[k] <= '0;
            out_valid_q <= 1'b0;
            out_data_q  <= '0;
            out_zero_q  <= 1'b0;
`ifdef SHIFTER_STICKY_EN
            out_sticky_q <= 1'b0;
`endif
        end else begin
            pipe_q      <= pipe_d;
            out_valid_q <= out_valid_d;
            out_data_q  <= out_data_d;
            out_zero_q  <= out_zero_d;
`ifdef SHIFTER_STICKY_EN
            out_sticky_q <= out_sticky_d;
`endif
        end
    end

    assign out_valid = out_valid_q;
    assign out_data  = out_data_q;
    assign out_zero  = out_zero_q;
`ifdef SHIFTER_STICKY_EN
    assign out_sticky = out_sticky_q;
`endif

endmodule

// File: tb/tb_pipelined_barrel_shifter.sv
// tb/tb_pipelined_barrel_shifter.sv - bench for pipelined_barrel_shifter at WIDTH 8/32/64
`timescale 1ns/1ps
module tb_pipelined_barrel_shifter;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic        rst_n;
    logic [2:0]  in_valid, out_ready;
    logic [63:0] in_data  [3];
    logic [5:0]  in_shamt [3];
    logic [1:0]  in_op    [3];
    logic [2:0]  in_ready, out_valid, out_zero;
`ifdef SHIFTER_STICKY_EN
    logic [2:0]  out_sticky;
`endif
    logic [7:0]  od0;
    logic [31:0] od1;
    logic [63:0] od2;
    logic [63:0] out_data [3];

    assign out_data[0] = {56'd0, od0};
    assign out_data[1] = {32'd0, od1};
    assign out_data[2] = od2;

    int checks = 0;
    int errors = 0;

    pipelined_barrel_shifter #(.WIDTH(8), .PIPELINED(0)) u_dut8 (
        .clk(clk), .rst_n(rst_n), .in_valid(in_valid[0]), .in_ready(in_ready[0]),
        .in_data(in_data[0][7:0]), .in_shamt(in_shamt[0][2:0]), .in_op(in_op[0]),
        .out_valid(out_valid[0]), .out_ready(out_ready[0]), .out_data(od0), .out_zero(out_zero[0])
`ifdef SHIFTER_STICKY_EN
        , .out_sticky(out_sticky[0])
`endif
    );

    pipelined_barrel_shifter #(.WIDTH(32), .PIPELINED(1)) u_dut32 (
        .clk(clk), .rst_n(rst_n), .in_valid(in_valid[1]), .in_ready(in_ready[1]),
        .in_data(in_data[1][31:0]), .in_shamt(in_shamt[1][4:0]), .in_op(in_op[1]),
        .out_valid(out_valid[1]), .out_ready(out_ready[1]), .out_data(od1), .out_zero(out_zero[1])
`ifdef SHIFTER_STICKY_EN
        , .out_sticky(out_sticky[1])
`endif
    );

    pipelined_barrel_shifter #(.WIDTH(64), .PIPELINED(1)) u_dut64 (
        .clk(clk), .rst_n(rst_n), .in_valid(in_valid[2]), .in_ready(in_ready[2]),
        .in_data(in_data[2]), .in_shamt(in_shamt[2]), .in_op(in_op[2]),
        .out_valid(out_valid[2]), .out_ready(out_ready[2]), .out_data(od2), .out_zero(out_zero[2])
`ifdef SHIFTER_STICKY_EN
        , .out_sticky(out_sticky[2])
`endif
    );

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s got=%h exp=%h", tag, got, exp);
        end
    endtask

    function automatic int w_of(input int j);
        return (j == 0) ? 8 : ((j == 1) ? 32 : 64);
    endfunction

    // Reference: {sticky, zero, result} from plain shift arithmetic.
    function automatic logic [65:0] model(input logic [63:0] din, input int s, input logic [1:0] op, input int w);
        logic [63:0] m, d, r;
        logic        st;
        m  = (w == 64) ? 64'hFFFF_FFFF_FFFF_FFFF : ((64'd1 << w) - 64'd1);
        d  = din & m;
        st = 1'b0;
        case (op)
            2'b00: begin r = d >> s; st = |(d & ((64'd1 << s) - 64'd1)); end
            2'b01: begin r = (d << s) & m; st = (s == 0) ? 1'b0 : |(d >> (w - s)); end
            2'b10: begin
                r  = (d >> s) | (d[w-1] ? (m & ~(m >> s)) : 64'd0);
                st = |(d & ((64'd1 << s) - 64'd1));
            end
            default: r = ((d >> s) | (d << (w - s))) & m;
        endcase
        return {st, (r == 64'd0), r};
    endfunction

    for (genvar g = 0; g < 3; g++) begin : mon
        logic [65:0] q[$];
        int          n_out = 0;
        logic        prev_stall = 1'b0;
        logic [63:0] prev_data;
        logic [65:0] e;
        always @(negedge clk) begin
            if (!rst_n) begin
                q.delete();
                prev_stall = 1'b0;
            end else begin
                if (prev_stall) begin
                    check($sformatf("stable_data%0d", g), out_data[g], prev_data);
                    check($sformatf("stable_valid%0d", g), 64'(out_valid[g]), 64'd1);
                end
                check($sformatf("in_ready%0d", g), 64'(in_ready[g]), 64'(!out_valid[g] || out_ready[g]));
                if (out_valid[g] && out_ready[g]) begin
                    if (q.size() == 0) begin
                        check($sformatf("spurious_out%0d", g), 64'(out_valid[g]), 64'd0);
                    end else begin
                        e = q.pop_front();
                        check($sformatf("data%0d", g), out_data[g], e[63:0]);
                        check($sformatf("zero%0d", g), 64'(out_zero[g]), 64'(e[64]));
`ifdef SHIFTER_STICKY_EN
                        check($sformatf("sticky%0d", g), 64'(out_sticky[g]), 64'(e[65]));
`endif
                        n_out++;
                    end
                end
                if (in_valid[g] && in_ready[g])
                    q.push_back(model(in_data[g], int'(in_shamt[g]), in_op[g], w_of(g)));
                prev_stall = out_valid[g] && !out_ready[g];
                prev_data  = out_data[g];
            end
        end
    end

    task automatic run_one(input int j, input logic [1:0] op, input logic [63:0] d, input int s,
                           input logic [63:0] exp, input logic ez, input logic es, input int lat_e,
                           input string tag);
        int lat;
        @(posedge clk); #1;
        in_valid[j] = 1'b1; in_op[j] = op; in_data[j] = d; in_shamt[j] = 6'(s); out_ready[j] = 1'b1;
        @(posedge clk); #1;
        in_valid[j] = 1'b0;
        lat = 1;
        while (!out_valid[j] && lat < 50) begin
            @(posedge clk); #1;
            lat++;
        end
        check({tag, "_lat"}, 64'(lat), 64'(lat_e));
        check(tag, out_data[j], exp);
        check({tag, "_zero"}, 64'(out_zero[j]), 64'(ez));
`ifdef SHIFTER_STICKY_EN
        check({tag, "_sticky"}, 64'(out_sticky[j]), 64'(es));
`else
        if (es === 1'bx) $display("sticky expectation undefined for %s", tag);
`endif
        repeat (8) @(posedge clk);
    endtask

    initial begin
        int          stale, i, n0;
        logic        acc1;
        logic [2:0]  acc;
        int          nops [3];

        rst_n = 1'b0; in_valid = '0; out_ready = '1;
        for (int j = 0; j < 3; j++) begin in_data[j] = '0; in_shamt[j] = '0; in_op[j] = '0; end
        #2;
        for (int j = 0; j < 3; j++) begin
            check($sformatf("rst_valid%0d", j), 64'(out_valid[j]), 64'd0);
            check($sformatf("rst_data%0d", j), out_data[j], 64'd0);
            check($sformatf("rst_zero%0d", j), 64'(out_zero[j]), 64'd0);
            check($sformatf("rst_in_ready%0d", j), 64'(in_ready[j]), 64'd1);
        end
        repeat (3) @(posedge clk);
        #2 rst_n = 1'b1;

        run_one(1, 2'b00, 64'h80000F01, 4, 64'h080000F0, 1'b0, 1'b1, 5, "srl");
        run_one(1, 2'b01, 64'h80000F01, 4, 64'h0000F010, 1'b0, 1'b1, 5, "sll");
        run_one(1, 2'b10, 64'h80000F01, 4, 64'hF80000F0, 1'b0, 1'b1, 5, "sra");
        run_one(1, 2'b11, 64'h80000F01, 4, 64'h180000F0, 1'b0, 1'b0, 5, "ror");
        for (int op = 0; op < 4; op++)
            run_one(1, 2'(op), 64'hDEADBEEF, 0, 64'hDEADBEEF, 1'b0, 1'b0, 5, $sformatf("sh0_op%0d", op));
        run_one(1, 2'b00, 64'h80000000, 31, 64'h00000001, 1'b0, 1'b0, 5, "srl31");
        run_one(1, 2'b10, 64'h80000000, 31, 64'hFFFFFFFF, 1'b0, 1'b0, 5, "sra31");
        run_one(1, 2'b01, 64'h80000000, 31, 64'h00000000, 1'b1, 1'b1, 5, "sll31");
        run_one(1, 2'b00, 64'h00000011, 4, 64'h00000001, 1'b0, 1'b1, 5, "sticky_set");
        run_one(1, 2'b00, 64'h00000010, 4, 64'h00000001, 1'b0, 1'b0, 5, "sticky_clr");
        run_one(0, 2'b00, 64'hA5, 1, 64'h52, 1'b0, 1'b1, 1, "w8_comb");
        run_one(2, 2'b11, 64'h1, 1, 64'h8000000000000000, 1'b0, 1'b0, 6, "w64_ror");

        // Reset with operations in flight and a valid result at the output.
        for (int k = 0; k < 6; k++) begin
            @(posedge clk); #1;
            in_valid[1] = 1'b1; in_op[1] = 2'b00; in_shamt[1] = '0; in_data[1] = 64'h12345678 + 64'(k);
        end
        @(posedge clk); #1;
        in_valid[1] = 1'b0;
        #2 rst_n = 1'b0;
        #1;
        check("midrst_valid", 64'(out_valid[1]), 64'd0);
        check("midrst_data", out_data[1], 64'd0);
        check("midrst_in_ready", 64'(in_ready[1]), 64'd1);
        repeat (2) @(posedge clk);
        #2 rst_n = 1'b1;
        stale = 0;
        repeat (12) begin @(negedge clk); if (out_valid[1]) stale++; end
        check("midrst_stale", 64'(stale), 64'd0);

        // Backpressure: 8 back-to-back ops with a 4-cycle out_ready hold.
        n0 = mon[1].n_out; i = 0; acc1 = 1'b1;
        for (int c = 0; c < 40; c++) begin
            @(posedge clk); #1;
            out_ready[1] = !(c >= 6 && c < 10);
            if (acc1) begin
                if (i < 8) begin
                    in_valid[1] = 1'b1; in_op[1] = 2'(i % 4);
                    in_data[1] = 64'($urandom); in_shamt[1] = 6'($urandom % 32);
                end else in_valid[1] = 1'b0;
            end
            @(negedge clk);
            if (c >= 6 && c < 10) check("bp_in_ready", 64'(in_ready[1]), 64'd0);
            acc1 = !in_valid[1] || in_ready[1];
            if (in_valid[1] && in_ready[1]) i++;
        end
        check("bp_count", 64'(mon[1].n_out - n0), 64'd8);

        // Random traffic on all three widths.
        acc = '1;
        for (int j = 0; j < 3; j++) nops[j] = 0;
        for (int cyc = 0; cyc < 40000 && (nops[0] < 10000 || nops[1] < 10000 || nops[2] < 10000); cyc++) begin
            @(posedge clk); #1;
            for (int j = 0; j < 3; j++) begin
                out_ready[j] = ($urandom % 8) != 0;
                if (acc[j]) begin
                    in_valid[j] = ($urandom % 8) != 0;
                    in_data[j]  = {$urandom, $urandom};
                    in_op[j]    = 2'($urandom % 4);
                    in_shamt[j] = 6'($urandom % w_of(j));
                end
            end
            @(negedge clk);
            for (int j = 0; j < 3; j++) begin
                acc[j] = !in_valid[j] || in_ready[j];
                if (in_valid[j] && in_ready[j]) nops[j]++;
            end
        end
        @(posedge clk); #1;
        in_valid = '0; out_ready = '1;
        repeat (10) @(posedge clk);
        for (int j = 0; j < 3; j++) check($sformatf("random_ops%0d", j), 64'(nops[j] >= 10000), 64'd1);
        check("drain0", 64'(mon[0].q.size()), 64'd0);
        check("drain1", 64'(mon[1].q.size()), 64'd0);
        check("drain2", 64'(mon[2].q.size()), 64'd0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/pipelined_barrel_shifter.md
Name: pipelined_barrel_shifter

Overview:
- Parametrised, pipelined barrel shifter for the execute stage of the 5-stage CPU.
- Supports logical right, logical left, arithmetic right and rotate right on a WIDTH-bit operand.
- Built from log2(WIDTH) mux levels; level k shifts by 2^k when amount bit k is set.
- Optional per-level pipeline registers and a valid/ready handshake allow a multi-cycle execute path and stalls from downstream.

Parameters:
- WIDTH, 32, operand width; power of two, 8..64.
- SH_W, $clog2(WIDTH), shift-amount width; derived, not overridden.
- PIPELINED, 0, 0 = all levels combinational with one output register (latency 1); 1 = register after every level (latency SH_W).

Ports:
- clk  input  1  rising-edge clock
- rst_n  input  1  asynchronous active-low reset
- in_valid  input  1  operand and command valid
- in_ready  output  1  shifter can accept this cycle
- in_data  input  WIDTH  operand
- in_shamt  input  SH_W  shift amount
- in_op  input  2  00 SRL, 01 SLL, 10 SRA, 11 ROR
- out_valid  output  1  result valid
- out_ready  input  1  consumer accepts result
- out_data  output  WIDTH  shifted result
- out_zero  output  1  out_data == 0

Behaviour:
- Reset (asynchronous, rst_n low): all stage valid bits, out_valid, out_data and out_zero are 0. in_ready is 1 while reset is held. Any in-flight operation is discarded. The first transfer can occur on the first rising edge after rst_n rises.
- Transfer in: occurs on a rising edge with in_valid && in_ready. Transfer out: occurs on a rising edge with out_valid && out_ready.
- Advance enable: adv = !out_valid || out_ready. When adv=1, every stage register loads from the previous stage, including bubbles. When adv=0, every stage holds. in_ready = adv, which is combinational from out_ready.
- Latency, no stall: result appears 1 cycle after accept (PIPELINED=0) or SH_W cycles after accept (PIPELINED=1). Throughput is 1 operation per cycle.
- Order: results are strictly in order. out_data, out_zero and out_valid stay stable while out_valid && !out_ready.
- Shift semantics:
  - SRL: zero fill from the MSB.
  - SRA: fill with in_data[WIDTH-1].
  - ROR: bits leaving bit 0 re-enter at the MSB.
  - SLL: zero fill from the LSB. Implemented as bit-reverse, SRL, bit-reverse. Must be bit-exact with in_data << in_shamt.
- Shift amount: in_shamt = 0 returns in_data unchanged for every op. Amounts are SH_W bits, so no amount is at or beyond WIDTH.
- Pipeline contents (PIPELINED=1): each stage register carries the partial result, the remaining shamt bits, op, the sign bit and valid.
- Bubbles: stages holding bubbles still advance, but their data is don't-care. out_data updates only when a valid result lands in the output stage.
- Simultaneous in- and out-transfer on the same edge is legal, including with a full pipeline.
- in_valid while in_ready=0: no transfer. The upstream stage must hold its inputs.

Optional Feature:
- Macro: SHIFTER_STICKY_EN.
- Defined:
  - Adds output port out_sticky (1 bit) = OR of all bits shifted out past bit 0 for SRL/SRA, or past bit WIDTH-1 for SLL.
  - out_sticky is 0 for ROR and for shamt = 0.
  - It is carried through the pipeline alongside the data and is 0 on reset.
- Undefined: the port and its logic are absent; all other behaviour is identical.

Test Plan:
- Reset: WIDTH=32, PIPELINED=1, assert rst_n low mid-stream with 3 ops in flight -> out_valid=0, out_data=0 immediately. After release, no stale result appears.
- Modes: in_data=0x80000F01, shamt=4, out_ready=1, one op of each kind:
  - SRL -> 0x080000F0
  - SLL -> 0x0000F010
  - SRA -> 0xF80000F0
  - ROR -> 0x180000F0
  - Each result appears after exactly 5 cycles (PIPELINED=1) or 1 cycle (PIPELINED=0).
- Boundaries: shamt=0 on 0xDEADBEEF -> 0xDEADBEEF for all ops. shamt=31 on 0x80000000 -> SRL 0x00000001, SRA 0xFFFFFFFF, SLL 0x00000000 with out_zero=1.
- Backpressure: stream 8 back-to-back ops, hold out_ready=0 for 4 cycles mid-stream -> in_ready=0 during the hold, outputs stable, all 8 results in order with none lost or duplicated.
- Sticky (SHIFTER_STICKY_EN): SRL of 0x00000011 by 4 -> out_data=0x00000001, out_sticky=1. SRL of 0x00000010 by 4 -> out_sticky=0.
- Random: 10k random data/shamt/op values with random out_ready, at WIDTH=8, 32 and 64 -> bit-exact match against a behavioural model.
